// File: rtl/skid_reg.sv
// skid_reg: two-entry skid buffer (main + skid register) between a valid/ready
// producer and consumer. in_ready depends only on registered state, so there
// is no combinational path from out_ready back to in_ready.
module skid_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] main_next;
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] skid_next;
  logic             in_fire;
  logic             out_fire;

  // Handshake outputs are pure decodes of the registered state.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign count     = (state == FULL) ? 2'd2 :
                     (state == ONE)  ? 2'd1 : 2'd0;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // State and storage registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state  <= state_next;
      main_q <= main_next;
      skid_q <= skid_next;
    end
  end

  // Next-state and data movement; flush overrides whatever the fires asked for.
  always_comb begin
    state_next = state;
    main_next  = main_q;
    skid_next  = skid_q;
    case (state)
      EMPTY: begin
        if (in_fire) begin
          main_next  = in_data;
          state_next = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_next = in_data;
        end else if (in_fire) begin
          skid_next  = in_data;
          state_next = FULL;
        end else if (out_fire) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          main_next  = skid_q;
          state_next = ONE;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
    if (flush) begin
      state_next = EMPTY;
    end
  end

endmodule

// File: tb/tb_skid_reg.sv
// tb_skid_reg: table-driven vectors plus hand-written corner sequences, with a
// queue-based FIFO reference model acting as the scoreboard for data order.
module tb_skid_reg;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready = 1'b0;
  logic             flush = 1'b0;
  logic [1:0]       count;

  int tests = 0;
  int fails = 0;

  logic [WIDTH-1:0] model_q[$];

  typedef struct {
    logic             iv;
    logic [WIDTH-1:0] d;
    logic             ordy;
    logic             fl;
    logic [1:0]       e_count;
    logic             e_ov;
    logic [WIDTH-1:0] e_od;
    logic             e_ir;
  } vec_t;

  vec_t vecs[7];

  skid_reg #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .flush     (flush),
    .count     (count)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Called at a falling edge: drive inputs, check pre-edge outputs against the
  // reference FIFO, update the model for the coming rising edge, and return at
  // the next falling edge.
  task automatic apply_stimulus(input logic iv, input logic [WIDTH-1:0] d,
                                input logic ordy, input logic fl);
    logic             model_ready;
    logic [WIDTH-1:0] exp_word;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #4;
    model_ready = (model_q.size() < 2);
    check_output("pre_in_ready", {31'd0, in_ready}, {31'd0, model_ready});
    check_output("pre_out_valid", {31'd0, out_valid}, {31'd0, model_q.size() > 0});
    check_output("pre_count", {30'd0, count}, model_q.size());
    if (model_q.size() > 0) begin
      if (ordy && !fl) begin
        exp_word = model_q.pop_front();
        check_output("sb_pop", {24'd0, out_data}, {24'd0, exp_word});
      end else begin
        check_output("sb_head", {24'd0, out_data}, {24'd0, model_q[0]});
      end
    end
    if (fl) begin
      model_q.delete();
    end else if (iv && model_ready) begin
      model_q.push_back(d);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset, push 0x11, drain; fill A1/A2, reject A3, drain in order.
    vecs[0] = '{1'b1, 8'h11, 1'b1, 1'b0, 2'd1, 1'b1, 8'h11, 1'b1};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{1'b1, 8'hA1, 1'b0, 1'b0, 2'd1, 1'b1, 8'hA1, 1'b1};
    vecs[3] = '{1'b1, 8'hA2, 1'b0, 1'b0, 2'd2, 1'b1, 8'hA1, 1'b0};
    vecs[4] = '{1'b1, 8'hA3, 1'b0, 1'b0, 2'd2, 1'b1, 8'hA1, 1'b0};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 2'd1, 1'b1, 8'hA2, 1'b1};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 1'b1};

    @(negedge clk);
    check_output("reset_count", {30'd0, count}, 32'd0);
    check_output("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check_output("reset_out_data", {24'd0, out_data}, 32'd0);
    check_output("reset_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      apply_stimulus(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl);
      check_output($sformatf("vec%0d_count", i), {30'd0, count}, {30'd0, vecs[i].e_count});
      check_output($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
      check_output($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].e_ir});
      if (vecs[i].e_ov) begin
        check_output($sformatf("vec%0d_out_data", i), {24'd0, out_data}, {24'd0, vecs[i].e_od});
      end
    end

    // Continuous streaming: one word per cycle, occupancy pinned at 1.
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(1'b1, 8'(i), 1'b1, 1'b0);
      check_output("stream_count", {30'd0, count}, 32'd1);
      check_output("stream_in_ready", {31'd0, in_ready}, 32'd1);
      check_output("stream_out_data", {24'd0, out_data}, i);
    end
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
    check_output("stream_drained", {30'd0, count}, 32'd0);

    // Flush while FULL, with a word presented in the same cycle.
    apply_stimulus(1'b1, 8'hB1, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'hB2, 1'b0, 1'b0);
    check_output("flush_prefull", {30'd0, count}, 32'd2);
    apply_stimulus(1'b1, 8'h55, 1'b0, 1'b1);
    check_output("flush_count", {30'd0, count}, 32'd0);
    check_output("flush_out_valid", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
      check_output("flush_stays_empty", {31'd0, out_valid}, 32'd0);
    end
    apply_stimulus(1'b1, 8'hC1, 1'b0, 1'b0);
    check_output("after_flush_data", {24'd0, out_data}, 32'hC1);
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset mid-cycle while FULL.
    apply_stimulus(1'b1, 8'hD1, 1'b0, 1'b0);
    apply_stimulus(1'b1, 8'hD2, 1'b0, 1'b0);
    check_output("areset_prefull", {30'd0, count}, 32'd2);
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check_output("areset_count", {30'd0, count}, 32'd0);
    check_output("areset_out_valid", {31'd0, out_valid}, 32'd0);
    check_output("areset_out_data", {24'd0, out_data}, 32'd0);
    check_output("areset_in_ready", {31'd0, in_ready}, 32'd1);
    model_q.delete();
    @(negedge clk);
    rst = 1'b1;
    apply_stimulus(1'b1, 8'hE1, 1'b0, 1'b0);
    check_output("areset_first_word", {24'd0, out_data}, 32'hE1);
    check_output("areset_first_count", {30'd0, count}, 32'd1);
    apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
    check_output("areset_drained", {30'd0, count}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/skid_reg.md
SKID_REG -- requirements
Module: skid_reg

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the payload width in bits.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 in_valid  input  1  SHALL mean the upstream stage presents a word.
REQ-005 in_data  input  WIDTH  SHALL be the upstream payload, sampled only on an input fire.
REQ-006 in_ready  output  1  SHALL mean the block will accept a word this cycle.
REQ-007 out_valid  output  1  SHALL mean out_data holds a valid word for downstream.
REQ-008 out_data  output  WIDTH  SHALL be the downstream payload.
REQ-009 out_ready  input  1  SHALL mean downstream takes the word this cycle.
REQ-010 flush  input  1  SHALL be a synchronous discard-all request.
REQ-011 count  output  2  SHALL be the current occupancy (0, 1 or 2).

Function
REQ-012 Input fire (in_valid & in_ready) and output fire (out_valid & out_ready) SHALL be the only events that move data.
REQ-013 The block SHALL hold two storage registers, main and skid, and a state of EMPTY, ONE or FULL, with count equal to 0, 1 or 2 respectively.
REQ-014 in_ready SHALL be 1 exactly when the state is not FULL, decoded from registered state only, with no combinational path from out_ready.
REQ-015 out_valid SHALL be 1 exactly when the state is not EMPTY; out_data SHALL always equal main.
REQ-016 EMPTY with input fire SHALL load main with in_data and go to ONE; otherwise it SHALL stay EMPTY.
REQ-017 ONE with both fires SHALL load main with in_data and stay ONE.
REQ-018 ONE with input fire only SHALL load skid with in_data and go to FULL.
REQ-019 ONE with output fire only SHALL go to EMPTY.
REQ-020 ONE with no fire SHALL hold main and stay ONE.
REQ-021 FULL with output fire SHALL copy skid to main and go to ONE; otherwise it SHALL hold both registers and stay FULL.
REQ-022 A word accepted on cycle N SHALL be visible on out_data with out_valid=1 at cycle N+1 at the earliest (latency 1).
REQ-023 Words SHALL leave in acceptance order, with none duplicated or lost.
REQ-024 While out_valid=1 and out_ready=0, out_data SHALL stay stable.
REQ-025 flush=1 SHALL force EMPTY on the next edge, overriding any fire in the same cycle; a word presented with flush SHALL be discarded, and data registers MAY keep stale contents.
REQ-026 in_data SHALL be ignored when in_valid=0, and out_ready SHALL be ignored when out_valid=0.

Reset
REQ-027 rst=0 SHALL immediately, without waiting for clk, force state EMPTY, main=0, skid=0, count=0, out_valid=0, out_data=0 and in_ready=1.
REQ-028 Deassertion of rst SHALL take effect at the next rising clk edge; a reset asserted mid-transfer SHALL discard both stored words.

Verification
REQ-029 Reset, then in_valid=1, in_data=0x11, out_ready=1 held for 1 cycle -> next cycle out_valid=1, out_data=0x11, count=1.
REQ-030 out_ready=0, push 0xA1 then 0xA2 -> count=2, in_ready=0, out_data=0xA1; a 0xA3 presented while FULL is not accepted.
REQ-031 From FULL (0xA1, 0xA2), set out_ready=1 for 2 cycles -> outputs 0xA1 then 0xA2, count goes 1 then 0, in_ready=1 after the first pop.
REQ-032 Continuous streaming 0x00..0x0F with in_valid=out_ready=1 -> one word per cycle, in order, count stays 1, in_ready stays 1.
REQ-033 In FULL, assert flush together with in_valid=1, in_data=0x55 -> next cycle count=0, out_valid=0, and 0x55 never appears.
REQ-034 Drive rst=0 asynchronously mid-cycle while FULL -> outputs reach reset values before the next clk edge, and the first word after release is the first word pushed after release.
